// File: rtl/sipo_defs.sv
// Shared definitions for the serial-to-parallel frame register: default frame
// width and the bit-order encodings used by the LSB_FIRST parameter.
package sipo_defs;
  localparam int DEFAULT_WIDTH   = 8;
  localparam int ORDER_MSB_FIRST = 0;
  localparam int ORDER_LSB_FIRST = 1;
endpackage

// File: rtl/sipo_bit_counter.sv
// Per-frame bit counter: counts accepted bits, wraps at WIDTH-1, flags the
// terminal count so the parent knows the current bit completes a frame.
module sipo_bit_counter
  import sipo_defs::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CW    = $clog2(WIDTH)
) (
  input  logic          clk,
  input  logic          clear_n,
  input  logic          en,
  input  logic          sclr,
  output logic [CW-1:0] cnt,
  output logic          tc
);

  logic [CW-1:0] cnt_q, cnt_d;

  assign tc  = (cnt_q == CW'(WIDTH-1));
  assign cnt = cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (sclr)    cnt_d = '0;
    else if (en) cnt_d = tc ? '0 : cnt_q + CW'(1);
  end

  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

endmodule

// File: rtl/sipo_frame_reg.sv
// Serial-in parallel-out frame register with valid/ready handoff, sticky
// overrun flag and synchronous restart.
module sipo_frame_reg
  import sipo_defs::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter int LSB_FIRST = ORDER_MSB_FIRST
) (
  input  logic                     clk,
  input  logic                     clear_n,
  input  logic                     si,
  input  logic                     si_valid,
  input  logic                     sync_clr,
  input  logic                     po_ready,
  output logic [WIDTH-1:0]         po,
  output logic                     po_valid,
  output logic                     overrun,
  output logic [$clog2(WIDTH)-1:0] bit_cnt
);

  localparam int CW = $clog2(WIDTH);

  logic [WIDTH-1:0] sr_q, sr_d, po_q, po_d, sh_val;
  logic             pv_q, pv_d, ovr_q, ovr_d;
  logic             tc, done;

  if (LSB_FIRST == ORDER_LSB_FIRST) begin : g_lsb
    assign sh_val = {si, sr_q[WIDTH-1:1]};
  end else begin : g_msb
    assign sh_val = {sr_q[WIDTH-2:0], si};
  end

  // sync_clr dominates, so the counter is only advanced on a real accept
  sipo_bit_counter #(.WIDTH(WIDTH), .CW(CW)) u_cnt (
    .clk     (clk),
    .clear_n (clear_n),
    .en      (si_valid),
    .sclr    (sync_clr),
    .cnt     (bit_cnt),
    .tc      (tc)
  );

  assign done = si_valid && !sync_clr && tc;

  always_comb begin
    sr_d  = sr_q;
    po_d  = po_q;
    pv_d  = pv_q;
    ovr_d = ovr_q;
    if (sync_clr) begin
      sr_d  = '0;
      po_d  = '0;
      pv_d  = 1'b0;
      ovr_d = 1'b0;
    end else begin
      if (si_valid) sr_d = sh_val;
      if (done) begin
        po_d = sh_val;
        pv_d = 1'b1;
        // a completion with the old word still unconsumed loses that word
        if (pv_q && !po_ready) ovr_d = 1'b1;
      end else if (pv_q && po_ready) begin
        pv_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      sr_q  <= '0;
      po_q  <= '0;
      pv_q  <= 1'b0;
      ovr_q <= 1'b0;
    end else begin
      sr_q  <= sr_d;
      po_q  <= po_d;
      pv_q  <= pv_d;
      ovr_q <= ovr_d;
    end
  end

  assign po       = po_q;
  assign po_valid = pv_q;
  assign overrun  = ovr_q;

endmodule
